// File: rtl/flag_frame_pkg.sv
// ============================================================================
// Module   : flag_frame_pkg
// Brief    : Shared types, flag indices and word classification for flag_frame_acc.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package flag_frame_pkg;

   typedef enum logic [0:0] {
      ACC  = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam int FLAG_ODD  = 0;
   localparam int FLAG_ZERO = 1;
   localparam int FLAG_ONES = 2;
   localparam int FLAG_HALF = 3;

   localparam int c_NUM_FLAGS = 4;
   localparam int c_MAX_WIDTH = 64;

   // Only the low 'width' bits of the zero-extended word take part.
   function automatic logic [c_NUM_FLAGS-1:0] classify_word(
      input logic [c_MAX_WIDTH-1:0] word,
      input int                     width
   );
      logic [c_NUM_FLAGS-1:0] flags;
      logic odd, zero, ones, half;
      odd  = 1'b0;
      zero = 1'b1;
      ones = 1'b1;
      half = 1'b1;
      for (int i = 0; i < c_MAX_WIDTH; i++) begin
         if (i < width) begin
            odd = odd ^ word[i];
            if (word[i]) zero = 1'b0;
            else         ones = 1'b0;
         end
      end
      for (int i = 0; i < c_MAX_WIDTH / 2; i++) begin
         if (i < width / 2) begin
            if (word[i] != word[i + width / 2]) half = 1'b0;
         end
      end
      flags            = '0;
      flags[FLAG_ODD]  = odd;
      flags[FLAG_ZERO] = zero;
      flags[FLAG_ONES] = ones;
      flags[FLAG_HALF] = half;
      return flags;
   endfunction

endpackage

`default_nettype wire

// File: rtl/flag_classify.sv
// ============================================================================
// Module   : flag_classify
// Brief    : Combinational WIDTH-bit word to 4-bit flag vector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flag_classify
   import flag_frame_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]       word,
   output logic [c_NUM_FLAGS-1:0] flags
);

   logic [c_MAX_WIDTH-1:0] w_word_ext;

   assign w_word_ext = c_MAX_WIDTH'(word);
   assign flags      = classify_word(w_word_ext, WIDTH);

endmodule

`default_nettype wire

// File: rtl/flag_frame_acc.sv
// ============================================================================
// Module   : flag_frame_acc
// Brief    : Per-frame flag counter on a valid/ready stream, one result per frame.
//            Optional early-frame flush port: define FLAG_FRAME_ACC_FLUSH_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flag_frame_acc
   import flag_frame_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int FRAME_LEN = 4,
   parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in,
`ifdef FLAG_FRAME_ACC_FLUSH_EN
   input  logic             flush,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] a,
   output logic [CNT_W-1:0] b,
   output logic [CNT_W-1:0] c,
   output logic [CNT_W-1:0] d,
   output logic [CNT_W-1:0] frame_cnt
);

   state_t                              r_state;
   logic [c_NUM_FLAGS-1:0][CNT_W-1:0]   r_acc;
   logic [c_NUM_FLAGS-1:0][CNT_W-1:0]   r_res;
   logic [CNT_W-1:0]                    r_idx;
   logic [CNT_W-1:0]                    r_frame_cnt;

   logic [c_NUM_FLAGS-1:0]              w_flags;
   logic [c_NUM_FLAGS-1:0][CNT_W-1:0]   w_acc_next;
   logic [CNT_W-1:0]                    w_idx_next;
   logic                                w_in_ready;
   logic                                w_accept;
   logic                                w_last;
   logic                                w_flush_end;
   logic                                w_frame_end;

   flag_classify #(
      .WIDTH (WIDTH)
   ) u_classify (
      .word  (in),
      .flags (w_flags)
   );

   assign w_in_ready = (r_state == ACC) || out_ready;
   assign w_accept   = in_valid && w_in_ready;
   assign w_last     = w_accept && (r_idx == CNT_W'(FRAME_LEN - 1));
   assign w_idx_next = r_idx + CNT_W'(w_accept);

   generate
      for (genvar k = 0; k < c_NUM_FLAGS; k++) begin : g_acc
         assign w_acc_next[k] = r_acc[k] + CNT_W'(w_accept && w_flags[k]);
      end
   endgenerate

`ifdef FLAG_FRAME_ACC_FLUSH_EN
   // An empty frame is never emitted: need either stored words or one arriving now.
   assign w_flush_end = flush && w_in_ready && ((r_idx != '0) || w_accept);
`else
   assign w_flush_end = 1'b0;
`endif

   assign w_frame_end = w_last || w_flush_end;

   // Frame end is only possible while in_ready=1, so a held result is never overwritten.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ACC;
         r_acc       <= '0;
         r_res       <= '0;
         r_idx       <= '0;
         r_frame_cnt <= '0;
      end else if (w_frame_end) begin
         r_res       <= w_acc_next;
         r_frame_cnt <= w_idx_next;
         r_acc       <= '0;
         r_idx       <= '0;
         r_state     <= HOLD;
      end else begin
         r_acc <= w_acc_next;
         r_idx <= w_idx_next;
         if ((r_state == HOLD) && out_ready) begin
            r_state <= ACC;
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = (r_state == HOLD);
   assign a         = r_res[FLAG_ODD];
   assign b         = r_res[FLAG_ZERO];
   assign c         = r_res[FLAG_ONES];
   assign d         = r_res[FLAG_HALF];
   assign frame_cnt = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_flag_frame_acc.sv
// ============================================================================
// Module   : tb_flag_frame_acc
// Brief    : Directed self-checking bench for flag_frame_acc (FRAME_LEN 4 and 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flag_frame_acc;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready, out_valid, out_ready;
   logic [7:0] din;
   logic [2:0] a, b, c, d, frame_cnt;
   logic       flush;

   logic       in_valid1, in_ready1, out_valid1, out_ready1;
   logic [7:0] din1;
   logic       a1, b1, c1, d1, fc1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   flag_frame_acc #(.WIDTH(8), .FRAME_LEN(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(din),
`ifdef FLAG_FRAME_ACC_FLUSH_EN
      .flush(flush),
`endif
      .out_valid(out_valid), .out_ready(out_ready),
      .a(a), .b(b), .c(c), .d(d), .frame_cnt(frame_cnt)
   );

   flag_frame_acc #(.WIDTH(8), .FRAME_LEN(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in(din1),
`ifdef FLAG_FRAME_ACC_FLUSH_EN
      .flush(1'b0),
`endif
      .out_valid(out_valid1), .out_ready(out_ready1),
      .a(a1), .b(b1), .c(c1), .d(d1), .frame_cnt(fc1)
   );

   // Called at a falling edge; the word is taken on the next rising edge.
   task automatic put(input logic [7:0] w);
      in_valid = 1'b1;
      din      = w;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({out_valid, a, b, c, d, frame_cnt} !== 16'h0) begin
         errors++;
         $display("FAIL reset_outputs: got ov=%b a=%0d b=%0d c=%0d d=%0d fc=%0d, want all 0",
                  out_valid, a, b, c, d, frame_cnt);
      end
      checks++;
      if (in_ready !== 1'b1 || out_valid1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: got in_ready=%b ov1=%b, want 1 0", in_ready, out_valid1);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      put(8'h01); put(8'hAA); put(8'h00); put(8'hFF);
      in_valid = 1'b0;
      checks++;
      if ({out_valid, a, b, c, d, frame_cnt} !== {1'b1, 3'd1, 3'd1, 3'd1, 3'd3, 3'd4}) begin
         errors++;
         $display("FAIL basic_frame: got ov=%b a=%0d b=%0d c=%0d d=%0d fc=%0d, want 1 1 1 1 3 4",
                  out_valid, a, b, c, d, frame_cnt);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_consume: got ov=%b, want 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      put(8'h0F); put(8'h0F); put(8'h0F); put(8'h0F);
      in_valid = 1'b1;
      din      = 8'h55;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if ({in_ready, out_valid, a, b, c, d, frame_cnt} !== {1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4}) begin
            errors++;
            $display("FAIL hold_cycle%0d: got rdy=%b ov=%b a=%0d b=%0d c=%0d d=%0d fc=%0d, want 0 1 0 0 0 0 4",
                     i, in_ready, out_valid, a, b, c, d, frame_cnt);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL hold_release: got ov=%b, want 0", out_valid);
      end
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if ({out_valid, a, b, c, d, frame_cnt} !== {1'b1, 3'd0, 3'd0, 3'd0, 3'd4, 3'd4}) begin
         errors++;
         $display("FAIL after_release: got ov=%b a=%0d b=%0d c=%0d d=%0d fc=%0d, want 1 0 0 0 4 4",
                  out_valid, a, b, c, d, frame_cnt);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int results = 0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      din       = 8'hFF;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready%0d: got %b, want 1", i, in_ready);
         end
         @(negedge clk);
         if (out_valid === 1'b1) begin
            results++;
            checks++;
            if ({a, b, c, d, frame_cnt} !== {3'd0, 3'd0, 3'd4, 3'd4, 3'd4}) begin
               errors++;
               $display("FAIL b2b_result: got a=%0d b=%0d c=%0d d=%0d fc=%0d, want 0 0 4 4 4",
                        a, b, c, d, frame_cnt);
            end
         end
      end
      in_valid = 1'b0;
      checks++;
      if (results != 2) begin
         errors++;
         $display("FAIL b2b_count: got %0d results, want 2", results);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      put(8'h00); put(8'h00);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      put(8'hFF); put(8'hFF); put(8'hFF);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_partial: got ov=%b, want 0", out_valid);
      end
      put(8'hFF);
      in_valid = 1'b0;
      checks++;
      if ({out_valid, b, c, frame_cnt} !== {1'b1, 3'd0, 3'd4, 3'd4}) begin
         errors++;
         $display("FAIL reset_mid_frame: got ov=%b b=%0d c=%0d fc=%0d, want 1 0 4 4",
                  out_valid, b, c, frame_cnt);
      end
      @(negedge clk);
   endtask

   task automatic test_frame_len1();
      out_ready1 = 1'b1;
      in_valid1  = 1'b1;
      din1       = 8'h07;
      @(negedge clk);
      checks++;
      if ({out_valid1, a1, b1, c1, d1, fc1} !== 6'b110001) begin
         errors++;
         $display("FAIL len1_07: got ov=%b a=%b b=%b c=%b d=%b fc=%b, want 1 1 0 0 0 1",
                  out_valid1, a1, b1, c1, d1, fc1);
      end
      din1 = 8'hFF;
      @(negedge clk);
      checks++;
      if ({out_valid1, a1, b1, c1, d1, fc1} !== 6'b100111) begin
         errors++;
         $display("FAIL len1_ff: got ov=%b a=%b b=%b c=%b d=%b fc=%b, want 1 0 0 1 1 1",
                  out_valid1, a1, b1, c1, d1, fc1);
      end
      din1 = 8'h00;
      @(negedge clk);
      in_valid1 = 1'b0;
      checks++;
      if ({out_valid1, a1, b1, c1, d1, fc1} !== 6'b101011) begin
         errors++;
         $display("FAIL len1_00: got ov=%b a=%b b=%b c=%b d=%b fc=%b, want 1 0 1 0 1 1",
                  out_valid1, a1, b1, c1, d1, fc1);
      end
      @(negedge clk);
      checks++;
      if (out_valid1 !== 1'b0) begin
         errors++;
         $display("FAIL len1_drain: got ov=%b, want 0", out_valid1);
      end
   endtask

`ifdef FLAG_FRAME_ACC_FLUSH_EN
   task automatic test_flush();
      out_ready = 1'b1;
      put(8'h00); put(8'hFF);
      in_valid = 1'b0;
      flush    = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks++;
      if ({out_valid, a, b, c, d, frame_cnt} !== {1'b1, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2}) begin
         errors++;
         $display("FAIL flush_frame: got ov=%b a=%0d b=%0d c=%0d d=%0d fc=%0d, want 1 0 1 1 2 2",
                  out_valid, a, b, c, d, frame_cnt);
      end
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_idle: got ov=%b, want 0", out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_idle_late: got ov=%b, want 0", out_valid);
      end
   endtask
`endif

   initial begin
      rst        = 1'b1;
      in_valid   = 1'b0;
      din        = 8'h00;
      out_ready  = 1'b0;
      flush      = 1'b0;
      in_valid1  = 1'b0;
      din1       = 8'h00;
      out_ready1 = 1'b1;
      test_reset();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_frame_len1();
`ifdef FLAG_FRAME_ACC_FLUSH_EN
      test_flush();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/flag_frame_acc.md
Name: flag_frame_acc

Overview:
- Parametrised, sequential successor to the 8-bit combinational flag decoder (outputs a/b/c/d).
- Accepts a valid/ready stream of WIDTH-bit words and classifies each word into four flags.
- Accumulates per-flag counts over a frame of FRAME_LEN words and emits one registered result per frame with valid/ready backpressure.
- Sits between a data source and the lab display/checker logic.

Parameters:
- WIDTH, 8, data word width; must be even and at least 2.
- FRAME_LEN, 4, words per frame; must be at least 1.
- CNT_W, $clog2(FRAME_LEN+1), width of each count output and of the frame index.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  source has a word.
- in_ready  out  1  block can accept a word.
- in  in  WIDTH  data word.
- out_valid  out  1  frame result is valid.
- out_ready  in  1  sink accepts the result.
- a  out  CNT_W  count of words with odd parity (XOR-reduce of the word equals 1).
- b  out  CNT_W  count of words equal to all zeros.
- c  out  CNT_W  count of words equal to all ones.
- d  out  CNT_W  count of words whose upper half equals their lower half.
- frame_cnt  out  CNT_W  number of words in the emitted frame; equals FRAME_LEN unless the optional flush ends the frame early.

Behaviour:
- Reset:
  - Applies at a rising edge while rst=1.
  - a, b, c, d, frame_cnt, out_valid, the internal accumulators and the word index all become 0.
  - Reset has priority over every other event.
  - Reset mid-frame discards the partial frame.
  - A pending result is dropped without a handshake.
- Accept rule:
  - in_ready = !out_valid || out_ready.
  - A word is accepted on a cycle where in_valid and in_ready are both 1.
- Per accepted word:
  - The four flags are computed combinationally.
  - Each accumulator increments by 1 when its flag is set.
  - The word index increments by 1.
- Frame end:
  - When the accepted word has index FRAME_LEN-1, the final counts (including that word) are registered onto a/b/c/d, and frame_cnt=FRAME_LEN.
  - out_valid rises on the next edge, so latency from the last word to out_valid is 1 cycle.
  - On that same edge the accumulators and the word index return to 0.
- Output hold:
  - While out_valid=1 and out_ready=0, a/b/c/d/frame_cnt/out_valid stay stable and in_ready=0.
- Output handshake:
  - When out_valid=1 and out_ready=1, out_valid falls on the next edge.
  - If another frame completes on that same cycle, the outputs are reloaded and out_valid stays 1.
  - With a continuously ready sink, throughput is one word per cycle with no bubble between frames.
- FRAME_LEN=1: every accepted word produces a result; each count is 0 or 1.
- Counts never overflow, because CNT_W is sized for FRAME_LEN.
- Simultaneous events: a word accepted on the cycle its result is consumed counts toward the next frame.
- in is ignored when the word is not accepted.
- State machine:
  - ACC: collecting; out_valid=0.
  - HOLD: result pending; out_valid=1.
  - ACC to HOLD on frame end.
  - HOLD to ACC on out handshake with no new frame end.
  - HOLD to HOLD on out handshake coinciding with a new frame end.

Optional Feature:
- Macro FLAG_FRAME_ACC_FLUSH_EN.
- When defined:
  - Adds input port flush (1 bit).
  - flush=1 while in_ready=1 ends the current frame early.
  - If a word is accepted on the same cycle, it is included in the frame.
  - The counts are emitted with frame_cnt equal to the number of words collected.
  - A flush with zero words collected and no word accepted is ignored, so no empty frame is ever emitted.
- When undefined: no flush port; frames are always exactly FRAME_LEN words.

Decomposition:
- Package flag_frame_pkg holds:
  - the state enum type (ACC, HOLD);
  - the flag index constants FLAG_ODD=0, FLAG_ZERO=1, FLAG_ONES=2, FLAG_HALF=3;
  - a function computing the 4-bit flag vector from a word.
- One sub-module, flag_classify: purely combinational WIDTH-bit word in, 4-bit flag vector out.
- Counters, index and handshake stay in the top.

Test Plan:
- WIDTH=8, FRAME_LEN=4, out_ready=1; send 0x01, 0xAA, 0x00, 0xFF on consecutive cycles -> one cycle after 0xFF: out_valid=1, a=1, b=1, c=1, d=3, frame_cnt=4.
- Backpressure: out_ready=0 after the first frame; keep in_valid=1 -> in_ready=0, outputs stable for 10 cycles; raise out_ready -> exactly one handshake, then the next frame is accepted.
- Back-to-back: 8 words 0xFF, out_ready=1 -> two results, each with c=4, d=4, a=0, b=0, with no idle cycle between accepted words.
- Reset mid-frame: accept 0x00, 0x00, then rst=1 for 1 cycle, then 0xFF ×4 -> single result with b=0, c=4; no output from the aborted partial frame.
- FRAME_LEN=1: send 0x07 -> a=1, b=0, c=0, d=0, frame_cnt=1 on the next cycle.
- With FLUSH_EN: accept 0x00, 0xFF, then pulse flush with in_valid=0 -> out_valid=1, b=1, c=1, frame_cnt=2; flush when idle -> no output.
